// File: rtl/xilinx_sync_width_convert_fifo.sv
// ---------------------------------------------------------------------------
// xilinx_sync_width_convert_fifo
//
// Purpose:
//   Single-clock FIFO that converts between write and read widths. One must
//   be an integer multiple of the other. Storage is an array of narrow words,
//   where narrow = min(C_WR_WIDTH, C_RD_WIDTH). Pointers and level count
//   narrow units. Packing is little-endian: the earliest narrow word sits in
//   the LSBs of any wide word. This holds for both up- and down-conversion.
//
// Ports:
//   clk        in   single clock, all logic on posedge
//   rst        in   asynchronous, active-high reset
//   wren       in   write request (accepted when !full)
//   din        in   write data, C_WR_WIDTH bits
//   full       out  fewer than WR_R narrow slots free
//   prog_full  out  level >= C_PROG_FULL_THRESH
//   overflow   out  one-cycle pulse after a rejected write
//   rden       in   read request (accepted when !empty)
//   dout       out  read data, C_RD_WIDTH bits
//   valid      out  dout carries an accepted read word this cycle
//   empty      out  fewer than RD_R narrow words stored
//   underflow  out  one-cycle pulse after a rejected read
//   level      out  occupancy in narrow units
//
// Optional feature:
//   XILINX_SYNC_WCFIFO_FWFT_EN - when this macro is defined, the FIFO runs in
//   first-word-fall-through mode. In that mode:
//     - the head word is driven combinationally from the array;
//     - valid = !empty;
//     - rden acts as a pop acknowledge;
//     - C_RD_LATENCY is ignored.
//   When the macro is undefined, the FIFO uses a free-running read pipeline
//   that is C_RD_LATENCY stages deep.
// ---------------------------------------------------------------------------
module xilinx_sync_width_convert_fifo #(
  parameter int C_WR_WIDTH         = 16,
  parameter int C_RD_WIDTH         = 32,
  parameter int C_NARROW_DEPTH     = 64,
  parameter int C_RD_LATENCY       = 2,
  parameter int C_PROG_FULL_THRESH = 48
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wren,
  input  logic [C_WR_WIDTH-1:0]                 din,
  output logic                                  full,
  output logic                                  prog_full,
  output logic                                  overflow,
  input  logic                                  rden,
  output logic [C_RD_WIDTH-1:0]                 dout,
  output logic                                  valid,
  output logic                                  empty,
  output logic                                  underflow,
  output logic [$clog2(C_NARROW_DEPTH+1)-1:0]   level
);

  localparam int MIN_W = (C_WR_WIDTH < C_RD_WIDTH) ? C_WR_WIDTH : C_RD_WIDTH;
  localparam int WR_R  = C_WR_WIDTH / MIN_W;
  localparam int RD_R  = C_RD_WIDTH / MIN_W;
  localparam int PTR_W = $clog2(C_NARROW_DEPTH);
  localparam int LVL_W = $clog2(C_NARROW_DEPTH+1);

  logic [MIN_W-1:0]      mem [C_NARROW_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic                  full_reg;
  logic                  empty_reg;
  logic                  prog_full_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;
  logic                  wacc;
  logic                  racc;
  logic [C_RD_WIDTH-1:0] rd_word;

  // Acceptance uses the registered flags. A simultaneous access on the
  // other side never rescues a rejected request.
  assign wacc = wren && !full_reg;
  assign racc = rden && !empty_reg;

  always_comb begin
    level_next = level_reg;
    if (wacc) level_next = level_next + LVL_W'(WR_R);
    if (racc) level_next = level_next - LVL_W'(RD_R);
  end

  // Array write: WR_R narrow slots per accepted write. The write pointer is
  // always a multiple of WR_R, so the slot group never straddles the wrap
  // point. Contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (wacc && !rst) begin
      for (int i = 0; i < WR_R; i++) begin
        mem[wr_ptr_reg + PTR_W'(i)] <= din[i*MIN_W +: MIN_W];
      end
    end
  end

  // Gather RD_R narrow slots starting at the head. The oldest slot goes to
  // the LSBs.
  generate
    for (genvar gi = 0; gi < RD_R; gi++) begin : g_rd_lane
      assign rd_word[gi*MIN_W +: MIN_W] = mem[rd_ptr_reg + PTR_W'(gi)];
    end
  endgenerate

  // Pointers, level and status flags. The flags are computed from the next
  // level, so they are exact on the cycle that follows an access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      prog_full_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wacc) wr_ptr_reg <= wr_ptr_reg + PTR_W'(WR_R);
      if (racc) rd_ptr_reg <= rd_ptr_reg + PTR_W'(RD_R);
      level_reg     <= level_next;
      full_reg      <= (level_next > LVL_W'(C_NARROW_DEPTH - WR_R));
      empty_reg     <= (level_next < LVL_W'(RD_R));
      prog_full_reg <= (level_next >= LVL_W'(C_PROG_FULL_THRESH));
      overflow_reg  <= wren && full_reg;
      underflow_reg <= rden && empty_reg;
    end
  end

  assign full      = full_reg;
  assign empty     = empty_reg;
  assign prog_full = prog_full_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
  assign level     = level_reg;

`ifdef XILINX_SYNC_WCFIFO_FWFT_EN

  // Head word falls through. The next word shows up as soon as rd_ptr moves.
  assign dout  = rd_word;
  assign valid = !empty_reg;

`else

  // Read pipeline. Stage 0 is the registered array read; later stages are
  // plain delay. Each stage loads data only when the word in front of it is
  // valid. As a result the last stage, and so dout, holds its value through
  // idle cycles.
  logic [C_RD_WIDTH-1:0]   pipe_data_reg [C_RD_LATENCY];
  logic [C_RD_LATENCY-1:0] pipe_valid_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_RD_LATENCY; i++) begin
        pipe_data_reg[i] <= '0;
      end
      pipe_valid_reg <= '0;
    end else begin
      pipe_valid_reg[0] <= racc;
      if (racc) pipe_data_reg[0] <= rd_word;
      for (int i = 1; i < C_RD_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        if (pipe_valid_reg[i-1]) pipe_data_reg[i] <= pipe_data_reg[i-1];
      end
    end
  end

  assign dout  = pipe_data_reg[C_RD_LATENCY-1];
  assign valid = pipe_valid_reg[C_RD_LATENCY-1];

`endif

endmodule

// File: tb/tb_xilinx_sync_width_convert_fifo.sv
// ---------------------------------------------------------------------------
// tb_xilinx_sync_width_convert_fifo
//
// Two instances are driven side by side:
//   u_up : 16-bit write, 32-bit read (up-conversion)
//   u_dn : 32-bit write, 16-bit read (down-conversion)
// Both use depth 64, read latency 2 and prog-full threshold 48.
//
// A reference model holds the contents of each FIFO as a queue of 16-bit
// words. Reads accepted by the model are scheduled on a pending list with
// the cycle in which their data is due. After every clock edge, the bench
// compares all outputs of both instances against the model.
// ---------------------------------------------------------------------------
module tb_xilinx_sync_width_convert_fifo;

  localparam int DEPTH  = 64;
  localparam int LAT    = 2;
  localparam int THRESH = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wren0 = 1'b0, rden0 = 1'b0, wren1 = 1'b0, rden1 = 1'b0;
  logic [15:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic [31:0] dout0;
  logic [15:0] dout1;
  logic        full0, pf0, ovf0, valid0, empty0, udf0;
  logic        full1, pf1, ovf1, valid1, empty1, udf1;
  logic [6:0]  level0, level1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  xilinx_sync_width_convert_fifo #(
    .C_WR_WIDTH(16), .C_RD_WIDTH(32), .C_NARROW_DEPTH(DEPTH),
    .C_RD_LATENCY(LAT), .C_PROG_FULL_THRESH(THRESH)
  ) u_up (
    .clk(clk), .rst(rst), .wren(wren0), .din(din0), .full(full0),
    .prog_full(pf0), .overflow(ovf0), .rden(rden0), .dout(dout0),
    .valid(valid0), .empty(empty0), .underflow(udf0), .level(level0)
  );

  xilinx_sync_width_convert_fifo #(
    .C_WR_WIDTH(32), .C_RD_WIDTH(16), .C_NARROW_DEPTH(DEPTH),
    .C_RD_LATENCY(LAT), .C_PROG_FULL_THRESH(THRESH)
  ) u_dn (
    .clk(clk), .rst(rst), .wren(wren1), .din(din1), .full(full1),
    .prog_full(pf1), .overflow(ovf1), .rden(rden1), .dout(dout1),
    .valid(valid1), .empty(empty1), .underflow(udf1), .level(level1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          id;
    int          due;
    logic [31:0] data;
  } pend_t;

  pend_t       pend[$];
  logic [15:0] mq0[$];
  logic [15:0] mq1[$];
  logic [31:0] last_dout [2];
  bit          e_ovf [2];
  bit          e_udf [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    pend.delete();
    last_dout[0] = '0;
    last_dout[1] = '0;
    e_ovf[0] = 0; e_ovf[1] = 0;
    e_udf[0] = 0; e_udf[1] = 0;
  endtask

  // Apply one cycle of requests to the model of FIFO 'id'.
  task automatic model_step(input int id, input bit wr, input bit rd, input logic [31:0] d);
    logic [15:0] q[$];
    int          wrr, rdr;
    bit          m_full, m_empty;
    logic [31:0] w;
    pend_t       p;
    if (id == 0) begin q = mq0; wrr = 1; rdr = 2; end
    else         begin q = mq1; wrr = 2; rdr = 1; end
    m_full    = (DEPTH - q.size()) < wrr;
    m_empty   = q.size() < rdr;
    e_ovf[id] = wr && m_full;
    e_udf[id] = rd && m_empty;
    if (rd && !m_empty) begin
      w = '0;
      for (int i = 0; i < rdr; i++) w[i*16 +: 16] = q.pop_front();
      p.id = id; p.due = cyc + LAT - 1; p.data = w;
      pend.push_back(p);
    end
    if (wr && !m_full) begin
      for (int i = 0; i < wrr; i++) q.push_back(d[i*16 +: 16]);
    end
    if (id == 0) mq0 = q; else mq1 = q;
  endtask

  task automatic check_dut(input int id, input logic [31:0] o_dout, input logic o_valid,
                           input logic o_full, input logic o_pf, input logic o_empty,
                           input logic o_ovf, input logic o_udf, input logic [6:0] o_level);
    int          sz, wrr, rdr;
    bit          ev;
    logic [31:0] ed;
    string       pfx;
    pfx = (id == 0) ? "up" : "dn";
    if (id == 0) begin sz = mq0.size(); wrr = 1; rdr = 2; end
    else         begin sz = mq1.size(); wrr = 2; rdr = 1; end
    ev = 0;
    ed = last_dout[id];
    for (int k = pend.size() - 1; k >= 0; k--) begin
      if (pend[k].id == id && pend[k].due <= cyc) begin
        if (pend[k].due == cyc) begin ev = 1; ed = pend[k].data; end
        pend.delete(k);
      end
    end
    last_dout[id] = ed;
    chk({pfx, ".valid"},     {31'h0, o_valid}, {31'h0, ev});
    chk({pfx, ".dout"},      o_dout,           ed);
    chk({pfx, ".level"},     {25'h0, o_level}, sz);
    chk({pfx, ".full"},      {31'h0, o_full},  {31'h0, (DEPTH - sz) < wrr});
    chk({pfx, ".empty"},     {31'h0, o_empty}, {31'h0, sz < rdr});
    chk({pfx, ".prog_full"}, {31'h0, o_pf},    {31'h0, sz >= THRESH});
    chk({pfx, ".overflow"},  {31'h0, o_ovf},   {31'h0, e_ovf[id]});
    chk({pfx, ".underflow"}, {31'h0, o_udf},   {31'h0, e_udf[id]});
  endtask

  task automatic step(input bit w0, input bit r0, input logic [15:0] d0,
                      input bit w1, input bit r1, input logic [31:0] d1);
    wren0 = w0; rden0 = r0; din0 = d0;
    wren1 = w1; rden1 = r1; din1 = d1;
    @(posedge clk);
    #1;
    model_step(0, w0, r0, {16'h0, d0});
    model_step(1, w1, r1, d1);
    check_dut(0, dout0, valid0, full0, pf0, empty0, ovf0, udf0, level0);
    check_dut(1, {16'h0, dout1}, valid1, full1, pf1, empty1, ovf1, udf1, level1);
    cyc++;
    wren0 = 0; rden0 = 0; wren1 = 0; rden1 = 0;
  endtask

  task automatic s0(input bit w, input bit r, input logic [15:0] d);
    step(w, r, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic s1(input bit w, input bit r, input logic [31:0] d);
    step(1'b0, 1'b0, 16'h0, w, r, d);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] cnt0;
    logic [31:0] cnt1;
    bit          w0, r0, w1, r1;

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_dut(0, dout0, valid0, full0, pf0, empty0, ovf0, udf0, level0);
    check_dut(1, {16'h0, dout1}, valid1, full1, pf1, empty1, ovf1, udf1, level1);
    @(negedge clk);
    rst = 1'b0;

    // Up-conversion: 0x0001, 0x0002 -> 0x00020001 two cycles after rden
    s0(1, 0, 16'h0001);
    s0(1, 0, 16'h0002);
    chk("up.empty_after_2w", {31'h0, empty0}, 32'h0);
    s0(0, 1, 16'h0);
    s0(0, 0, 16'h0);
    chk("up.first_word", dout0, 32'h00020001);
    chk("up.first_valid", {31'h0, valid0}, 32'h1);
    chk("up.level_zero", {25'h0, level0}, 32'h0);
    s0(0, 0, 16'h0);

    // Down-conversion: 0xAAAA5555 -> 0x5555 then 0xAAAA
    s1(1, 0, 32'hAAAA5555);
    s1(0, 1, 32'h0);
    s1(0, 1, 32'h0);
    chk("dn.empty_after_2r", {31'h0, empty1}, 32'h1);
    chk("dn.lo_half", {16'h0, dout1}, 32'h5555);
    s1(0, 0, 32'h0);
    chk("dn.hi_half", {16'h0, dout1}, 32'hAAAA);
    chk("dn.hi_valid", {31'h0, valid1}, 32'h1);
    s1(0, 0, 32'h0);

    // Underflow on empty; wren+rden on empty accepts only the write
    s0(0, 1, 16'h0);
    chk("up.underflow_pulse", {31'h0, udf0}, 32'h1);
    s0(0, 0, 16'h0);
    chk("up.underflow_clear", {31'h0, udf0}, 32'h0);
    s0(1, 1, 16'h0003);
    chk("up.wr_rd_on_empty_level", {25'h0, level0}, 32'h1);
    s0(1, 0, 16'h0004);
    s0(0, 1, 16'h0);
    s0(0, 0, 16'h0);
    chk("up.second_word", dout0, 32'h00040003);
    s0(0, 0, 16'h0);

    // Fill to full, prog_full edge, overflow, rd+wr while full
    for (int i = 1; i <= DEPTH; i++) begin
      s0(1, 0, 16'(i));
      if (i == THRESH - 1) chk("up.prog_full_below", {31'h0, pf0}, 32'h0);
      if (i == THRESH)     chk("up.prog_full_at",    {31'h0, pf0}, 32'h1);
    end
    chk("up.full_at_64", {31'h0, full0}, 32'h1);
    chk("up.level_64", {25'h0, level0}, 32'd64);
    s0(1, 0, 16'h0099);
    chk("up.overflow_pulse", {31'h0, ovf0}, 32'h1);
    chk("up.level_after_ovf", {25'h0, level0}, 32'd64);
    s0(1, 1, 16'h0100);
    chk("up.level_rdwr_full", {25'h0, level0}, 32'd62);
    s0(0, 0, 16'h0);
    chk("up.overflow_clear", {31'h0, ovf0}, 32'h0);
    repeat (31) s0(0, 1, 16'h0);
    repeat (3) s0(0, 0, 16'h0);

    // Random stream on both instances with incrementing data
    cnt0 = 16'h1000;
    cnt1 = 32'h2000_0000;
    for (int n = 0; n < 800; n++) begin
      w0 = ($urandom % 100) < 80;
      r0 = ($urandom % 100) < 45;
      w1 = ($urandom % 100) < 50;
      r1 = ($urandom % 100) < 80;
      step(w0, r0, cnt0, w1, r1, cnt1);
      cnt0 = cnt0 + 16'd1;
      cnt1 = cnt1 + 32'd1;
    end
    repeat (40) step(1'b0, 1'b1, 16'h0, 1'b0, 1'b1, 32'h0);
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0);

    // Reset mid-operation: level 20 with reads in flight
    for (int i = 0; i < 24; i++) s0(1, 0, 16'h0100 + 16'(i));
    s0(0, 1, 16'h0);
    s0(0, 1, 16'h0);
    chk("rst.level_before", {25'h0, level0}, 32'd20);
    #2;
    rst = 1'b1;
    #1;
    chk("rst.valid_immediate", {31'h0, valid0}, 32'h0);
    chk("rst.dout_immediate", dout0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.empty_after", {31'h0, empty0}, 32'h1);
    chk("rst.level_after", {25'h0, level0}, 32'h0);
    s0(1, 0, 16'hBEEF);
    s0(1, 0, 16'hCAFE);
    s0(0, 1, 16'h0);
    s0(0, 0, 16'h0);
    chk("rst.fresh_word", dout0, 32'hCAFEBEEF);
    s0(0, 0, 16'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
